// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader for the unified_system program
// memory. Accepts frames of the form
//   SYNC_BYTE, COUNT, BASE, COUNT data bytes, CHECK
// where CHECK is the 8-bit sum (mod 256) of the data bytes. Each data byte
// is written to the program-load port one cycle after it is accepted. A
// frame with a matching checksum raises load_done, and one cycle later
// start_execution when AUTO_START is set. A malformed frame raises
// frame_error instead.
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous, active-high reset
//   in_data            stream byte
//   in_valid           in_data is valid
//   in_ready           always 1; the loader never stalls the source
//   prog_addr          memory write address (registered)
//   prog_data_in       memory write data (registered)
//   prog_write_enable  one-cycle write strobe per data byte
//   load_done          level: a verified image is in memory
//   start_execution    level: CPU run request
//   frame_error        level: last frame was rejected
module program_loader #(
  parameter int unsigned              ADDR_WIDTH = 5,
  parameter int unsigned              DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]    SYNC_BYTE  = 8'hA5,
  parameter bit                       AUTO_START = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [DATA_WIDTH-1:0] prog_data_in,
  output logic                  prog_write_enable,
  output logic                  load_done,
  output logic                  start_execution,
  output logic                  frame_error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  // Remaining-count register must hold DEPTH itself, hence one extra bit.
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_BASE,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           remaining, remaining_nx;
  logic [ADDR_WIDTH-1:0]   addr, addr_nx;
  logic [DATA_WIDTH-1:0]   sum, sum_nx;

  logic [ADDR_WIDTH-1:0]   prog_addr_nx;
  logic [DATA_WIDTH-1:0]   prog_data_nx;
  logic                    write_nx;
  logic                    load_done_nx;
  logic                    start_nx;
  logic                    frame_error_nx;

  logic                    is_sync;
  logic                    count_bad;
  logic                    base_bad;

  assign in_ready = 1'b1;

  assign is_sync   = (in_data == SYNC_BYTE);
  assign count_bad = (in_data == '0) || (32'(in_data) > DEPTH);
  assign base_bad  = ((32'(in_data) >> ADDR_WIDTH) != 32'd0);

  always_comb begin
    state_nx       = state;
    remaining_nx   = remaining;
    addr_nx        = addr;
    sum_nx         = sum;
    prog_addr_nx   = prog_addr;
    prog_data_nx   = prog_data_in;
    write_nx       = 1'b0;
    load_done_nx   = load_done;
    start_nx       = start_execution;
    frame_error_nx = frame_error;

    // start_execution follows load_done by one cycle; a new sync below
    // clears both on the same edge, so it cannot re-arm itself.
    if (AUTO_START && load_done) begin
      start_nx = 1'b1;
    end

    if (in_valid) begin
      case (state)
        S_IDLE: begin
          if (is_sync) begin
            state_nx     = S_COUNT;
            remaining_nx = '0;
            addr_nx      = '0;
            sum_nx       = '0;
          end
        end

        S_COUNT: begin
          if (count_bad) begin
            state_nx       = S_ERROR;
            frame_error_nx = 1'b1;
          end else begin
            state_nx     = S_BASE;
            remaining_nx = CW'(in_data);
          end
        end

        S_BASE: begin
          if (base_bad) begin
            state_nx       = S_ERROR;
            frame_error_nx = 1'b1;
          end else begin
            state_nx = S_DATA;
            addr_nx  = ADDR_WIDTH'(in_data);
          end
        end

        S_DATA: begin
          write_nx     = 1'b1;
          prog_addr_nx = addr;
          prog_data_nx = in_data;
          addr_nx      = addr + ADDR_WIDTH'(1);
          sum_nx       = sum + in_data;
          remaining_nx = remaining - CW'(1);
          if (remaining == CW'(1)) begin
            state_nx = S_CHECK;
          end
        end

        S_CHECK: begin
          if (in_data == sum) begin
            state_nx     = S_DONE;
            load_done_nx = 1'b1;
          end else begin
            state_nx       = S_ERROR;
            frame_error_nx = 1'b1;
          end
        end

        S_DONE, S_ERROR: begin
          if (is_sync) begin
            state_nx       = S_COUNT;
            remaining_nx   = '0;
            addr_nx        = '0;
            sum_nx         = '0;
            load_done_nx   = 1'b0;
            start_nx       = 1'b0;
            frame_error_nx = 1'b0;
          end
        end

        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      remaining         <= '0;
      addr              <= '0;
      sum               <= '0;
      prog_addr         <= '0;
      prog_data_in      <= '0;
      prog_write_enable <= 1'b0;
      load_done         <= 1'b0;
      start_execution   <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      state             <= state_nx;
      remaining         <= remaining_nx;
      addr              <= addr_nx;
      sum               <= sum_nx;
      prog_addr         <= prog_addr_nx;
      prog_data_in      <= prog_data_nx;
      prog_write_enable <= write_nx;
      load_done         <= load_done_nx;
      start_execution   <= start_nx;
      frame_error       <= frame_error_nx;
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream loading stage for unified_system: receives a framed byte stream and drives its program-load port (prog_addr, prog_data_in, prog_write_enable).
- Writes a contiguous image into the 32-byte program/data memory, verifies a checksum, then signals load_done and, optionally, start_execution.
- Replaces hand-driven memory writes with a self-checking loader that a UART or host bridge can feed.

Parameters:
- ADDR_WIDTH, 5, memory address width; memory depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, byte and instruction width.
- SYNC_BYTE, 8'hA5, frame start marker.
- AUTO_START, 1, when 1, assert start_execution after a good frame.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- prog_addr  out  ADDR_WIDTH  memory write address.
- prog_data_in  out  DATA_WIDTH  memory write data.
- prog_write_enable  out  1  one-cycle write strobe per data byte.
- load_done  out  1  level; a verified image is in memory.
- start_execution  out  1  level; CPU run request.
- frame_error  out  1  level; last frame rejected.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0 except in_ready=1. Internal count, address and checksum registers cleared.
- Frame format: SYNC_BYTE, COUNT (1..2**ADDR_WIDTH), BASE, COUNT data bytes, CHECK.
  - CHECK = 8-bit sum (mod 256) of the data bytes only.
- States and transitions (on accepted bytes only):
  - IDLE: byte==SYNC_BYTE -> COUNT; any other byte is discarded.
  - COUNT: 0 or >2**ADDR_WIDTH -> ERROR; otherwise latch count -> BASE.
  - BASE: any bit above ADDR_WIDTH-1 set -> ERROR; otherwise latch address -> DATA.
  - DATA: each byte is written and decrements the remaining count; after the last byte -> CHECK.
  - CHECK: match -> DONE; mismatch -> ERROR.
  - DONE, ERROR: byte==SYNC_BYTE -> COUNT and clear load_done, start_execution and frame_error in that same cycle; other bytes are discarded.
- Sync bytes are treated as markers only in IDLE/DONE/ERROR. Inside COUNT..CHECK, 0xA5 is ordinary payload.
- Write timing: the data byte accepted at edge N appears on prog_addr/prog_data_in with prog_write_enable=1 during the cycle after edge N (registered outputs, latency 1). prog_write_enable is 0 in every other cycle.
- Address increments by 1 after each write, modulo 2**ADDR_WIDTH (31 -> 0 wraps).
- in_ready is 1 in every state; the loader never backpressures. in_valid gaps simply stall the FSM.
- Status outputs:
  - load_done rises in the cycle after CHECK is accepted with a matching sum.
  - start_execution rises one cycle after load_done when AUTO_START=1, else stays 0.
  - Both hold until reset or a new SYNC_BYTE.
  - frame_error rises in the cycle after the offending byte and holds the same way.
- A rejected frame leaves already-written bytes in memory and asserts neither load_done nor start_execution.
- Reset mid-frame: FSM returns to IDLE immediately. Any partial write strobe is dropped (prog_write_enable=0 asynchronously).

Test Plan:
- Good frame: A5,06,00,E0,C0,E1,C1,28,F2,5C -> six strobes at addr 0..5 with data E0,C0,E1,C1,28,F2; load_done=1 the cycle after 5C; start_execution=1 one cycle later; frame_error=0.
- Wrap-around: A5,04,1E,01,02,03,04,0A -> writes addr 30,31,0,1 with data 01..04; load_done=1.
- Bad checksum: same as the first case but CHECK=5D -> six writes occur, frame_error=1, load_done=0, start_execution=0. A following A5 clears frame_error.
- Illegal header: A5,00 -> frame_error=1, no writes. Separately, A5,03,20 -> frame_error=1 (BASE above 31), no writes.
- Gapped stream: good frame with in_valid low for 1-3 random cycles between bytes, plus a 0xA5 data byte inside the payload -> identical writes and load_done result. A leading garbage byte 0x11 before the sync is ignored.
- Reset mid-frame: assert reset after the third data byte -> all outputs 0 immediately. A subsequent complete good frame loads correctly and sets load_done=1.
